vga_sync_rx: RTL
================

# vga_sync_rx

Sync-side receiver for the 640x480 VGA timing stream. It samples active-low horizontal and vertical sync on the pixel strobe, measures line length and lines per frame, and locks once consecutive frames match the expected timing. While locked it regenerates pixel position and an active-video flag. It sits downstream of the VGA timing generator, or on an external sync input, for loopback checking and capture logic.

## Interface
- H_TOTAL, 800: expected pixels per line.
- H_SYNC, 96: hsync width in pixels.
- H_BP, 48: horizontal back porch.
- H_ACTIVE, 640: active pixels per line.
- V_TOTAL, 525: expected lines per frame.
- V_SYNC, 2: vsync width in lines.
- V_BP, 33: vertical back porch.
- V_ACTIVE, 480: active lines.
- TOL, 1: allowed deviation for both H_TOTAL and V_TOTAL checks.
- LOCK_FRAMES, 2: consecutive good frames required to lock.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_pix_stb  in  1  pixel strobe. All sampling and counting happens only on cycles where it is high.
- i_hs  in  1  horizontal sync, active low.
- i_vs  in  1  vertical sync, active low.
- o_locked  out  1  timing lock.
- o_active  out  1  high when o_locked is high and the position is inside the active window.
- o_x  out  10  active pixel x, 0..639; 0 when not active.
- o_y  out  9  active line y, 0..479; 0 when not active.
- o_frame_start  out  1  one-clock pulse when the vertical count restarts.
- o_err  out  1  one-clock pulse on loss of lock.
- o_line_len  out  11  last measured line length.
- o_frame_lines  out  11  last measured frame length, in lines.

## Operation
- Sampling:
  - hs_q and vs_q register i_hs and i_vs on each strobe.
  - An hs edge is hs_q=1 and i_hs=0 at a strobe. A vs edge is defined the same way.
- Horizontal counter h_cnt (11 bits):
  - Loads 0 on an hs edge; otherwise increments on each strobe, saturating at 2047.
  - On an hs edge, o_line_len <= h_cnt+1.
- Vertical tracking:
  - A vs edge sets vs_pend.
  - On an hs edge with vs_pend set, or with a vs edge on the same strobe: o_frame_lines <= v_cnt+1, v_cnt <= 0, vs_pend cleared, o_frame_start pulses (except in SEARCH).
  - On any other hs edge, v_cnt increments, saturating at 2047.
- Active window:
  - Horizontal: H_SYNC+H_BP <= h_cnt < that+H_ACTIVE.
  - Vertical: V_SYNC+V_BP <= v_cnt < that+V_ACTIVE.
  - o_x = h_cnt-144 and o_y = v_cnt-35 at the defaults; both are forced to 0 outside the window.
- State machine (SEARCH, MEASURE, LOCKED):
  - SEARCH: on the first frame restart, go to MEASURE with good=0 and the line-error flag cleared.
  - MEASURE, at each hs edge: if |o_line_len value - H_TOTAL| > TOL, set the line-error flag.
  - MEASURE, at each frame restart: if the frame length is within V_TOTAL±TOL and the line-error flag is clear, good++; otherwise good=0. Clear the flag either way.
  - MEASURE: when good reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED exits to SEARCH with an o_err pulse if any of these occur:
    - a line length is out of tolerance;
    - a frame length is out of tolerance;
    - h_cnt exceeds H_TOTAL+TOL with no hs edge;
    - v_cnt exceeds V_TOTAL+TOL with no restart.
  - The first line after a restart contributes no length check in MEASURE. A line length is checked only when the previous hs edge occurred in MEASURE or LOCKED.

## Timing
- Reset values:
  - o_locked, o_active, o_x, o_y, o_frame_start, o_err, o_line_len, o_frame_lines: all 0.
  - State SEARCH; h_cnt, v_cnt, good, vs_pend all 0.
  - hs_q and vs_q reset to 1.
- Latency:
  - Counters update on the clock edge of the strobe that detects the edge. h_cnt=0 corresponds to the first low hs sample.
  - o_x, o_y and o_active are decoded from the registered counters, so they are valid in the same cycle as the counter value.
- o_locked rises on the clock after the lock-qualifying restart strobe. It falls together with the o_err pulse.
- Strobe gaps of any length freeze all state.
- Reset asserted mid-frame forces all reset values on the next edge. Relocking then needs the full SEARCH→MEASURE sequence.

## Test plan
- Nominal 800x525 stream, stb every 2nd clk. Required response:
  - o_locked rises after the 3rd frame restart.
  - The first active pixel gives o_x=0, o_y=0, o_active=1; the last gives o_x=639, o_y=479.
  - o_line_len=800, o_frame_lines=525.
- 801-pixel lines with TOL=1 -> locks, o_line_len=801. Same stream with TOL=0 -> o_locked stays 0.
- Locked, then i_hs held high -> o_err pulse when h_cnt reaches 802; o_locked=0; state SEARCH.
- Locked, then one 524-line frame with TOL=0 -> o_err pulse, o_frame_lines=524, o_locked=0.
- hs and vs falling on the same strobe -> v_cnt=0 and an o_frame_start pulse on that strobe.
- i_rst pulsed mid-frame while locked -> all outputs 0 on the next clock; lock returns only after 3 more restarts.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing from active-low hs/vs, locks on
// consecutive good frames and regenerates pixel position while locked.
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int TOL         = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic        i_hs,
  input  logic        i_vs,
  output logic        o_locked,
  output logic        o_active,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_frame_start,
  output logic        o_err,
  output logic [10:0] o_line_len,
  output logic [10:0] o_frame_lines
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] TOL_C     = 11'(TOL);
  localparam logic [10:0] H_LIM_C   = 11'(H_TOTAL + TOL);
  localparam logic [10:0] V_LIM_C   = 11'(V_TOTAL + TOL);
  localparam logic [10:0] H_START_C = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_C   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_START_C = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END_C   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] CNT_MAX_C = 11'd2047;
  localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);

  function automatic logic in_tol(input logic [10:0] val, input logic [10:0] target);
    logic [10:0] diff;
    diff = (val >= target) ? (val - target) : (target - val);
    return (diff <= TOL_C);
  endfunction

  state_t      state_r, state_next_s;
  logic [7:0]  good_r, good_next_s;
  logic        line_err_r, line_err_next_s;
  logic        hs_q_r, vs_q_r, vs_pend_r, line_valid_r;
  logic [10:0] h_cnt_r, v_cnt_r, h_next_s, v_next_s;
  logic [10:0] line_len_s, frame_len_s;
  logic        hs_edge_s, vs_edge_s, restart_s;
  logic        line_bad_s, frame_bad_s, h_over_s, v_over_s;
  logic        locked_next_s, err_next_s, frame_start_next_s, active_next_s;
  logic [9:0]  x_next_s;
  logic [8:0]  y_next_s;

  assign hs_edge_s   = i_pix_stb & hs_q_r & ~i_hs;
  assign vs_edge_s   = i_pix_stb & vs_q_r & ~i_vs;
  assign restart_s   = hs_edge_s & (vs_pend_r | vs_edge_s);
  assign line_len_s  = h_cnt_r + 11'd1;
  assign frame_len_s = v_cnt_r + 11'd1;

  // Next counter values and the timing faults derived from them
  always_comb begin
    h_next_s = h_cnt_r;
    v_next_s = v_cnt_r;
    if (!i_pix_stb) begin
      h_next_s = h_cnt_r;
    end else if (hs_edge_s) begin
      h_next_s = 11'd0;
    end else if (h_cnt_r != CNT_MAX_C) begin
      h_next_s = h_cnt_r + 11'd1;
    end else begin
      h_next_s = h_cnt_r;
    end
    if (restart_s) begin
      v_next_s = 11'd0;
    end else if (hs_edge_s && (v_cnt_r != CNT_MAX_C)) begin
      v_next_s = v_cnt_r + 11'd1;
    end else begin
      v_next_s = v_cnt_r;
    end
    line_bad_s  = hs_edge_s & line_valid_r & ~in_tol(line_len_s, H_TOTAL_C);
    frame_bad_s = restart_s & ~in_tol(frame_len_s, V_TOTAL_C);
    h_over_s    = i_pix_stb & ~hs_edge_s & (h_next_s > H_LIM_C);
    v_over_s    = i_pix_stb & ~restart_s & (v_next_s > V_LIM_C);
  end

  // Sync sampling, counters and measured lengths
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_q_r        <= 1'b1;
      vs_q_r        <= 1'b1;
      h_cnt_r       <= 11'd0;
      v_cnt_r       <= 11'd0;
      vs_pend_r     <= 1'b0;
      line_valid_r  <= 1'b0;
      o_line_len    <= 11'd0;
      o_frame_lines <= 11'd0;
    end else if (i_pix_stb) begin
      hs_q_r  <= i_hs;
      vs_q_r  <= i_vs;
      h_cnt_r <= h_next_s;
      v_cnt_r <= v_next_s;
      if (restart_s) begin
        vs_pend_r     <= 1'b0;
        o_frame_lines <= frame_len_s;
      end else if (vs_edge_s) begin
        vs_pend_r <= 1'b1;
      end
      if (hs_edge_s) begin
        o_line_len   <= line_len_s;
        // a line is only trusted if it started while tracking
        line_valid_r <= (state_r != SEARCH);
      end
    end
  end

  // State, good-frame count and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= SEARCH;
      good_r        <= 8'd0;
      line_err_r    <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
      o_frame_start <= 1'b0;
      o_active      <= 1'b0;
      o_x           <= 10'd0;
      o_y           <= 9'd0;
    end else begin
      state_r       <= state_next_s;
      good_r        <= good_next_s;
      line_err_r    <= line_err_next_s;
      o_locked      <= locked_next_s;
      o_err         <= err_next_s;
      o_frame_start <= frame_start_next_s;
      o_active      <= active_next_s;
      o_x           <= x_next_s;
      o_y           <= y_next_s;
    end
  end

  // Next-state logic for SEARCH / MEASURE / LOCKED
  always_comb begin
    state_next_s    = state_r;
    good_next_s     = good_r;
    line_err_next_s = line_err_r;
    case (state_r)
      SEARCH: begin
        if (restart_s) begin
          state_next_s    = MEASURE;
          good_next_s     = 8'd0;
          line_err_next_s = 1'b0;
        end else begin
          state_next_s = SEARCH;
        end
      end
      MEASURE: begin
        if (restart_s) begin
          line_err_next_s = 1'b0;
          if (!frame_bad_s && !line_err_r && !line_bad_s) begin
            good_next_s = good_r + 8'd1;
            if ((good_r + 8'd1) >= LOCK_C) begin
              state_next_s = LOCKED;
            end else begin
              state_next_s = MEASURE;
            end
          end else begin
            good_next_s  = 8'd0;
            state_next_s = MEASURE;
          end
        end else if (line_bad_s) begin
          line_err_next_s = 1'b1;
        end else begin
          line_err_next_s = line_err_r;
        end
      end
      LOCKED: begin
        if (line_bad_s || frame_bad_s || h_over_s || v_over_s) begin
          state_next_s = SEARCH;
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: begin
        state_next_s = SEARCH;
      end
    endcase
  end

  // Output decode from next state and next counters, registered above
  always_comb begin
    locked_next_s      = (state_next_s == LOCKED);
    err_next_s         = (state_r == LOCKED) && (state_next_s == SEARCH);
    frame_start_next_s = restart_s && (state_r != SEARCH);
    active_next_s      = locked_next_s &&
                         (h_next_s >= H_START_C) && (h_next_s < H_END_C) &&
                         (v_next_s >= V_START_C) && (v_next_s < V_END_C);
    if (active_next_s) begin
      x_next_s = 10'(h_next_s - H_START_C);
      y_next_s = 9'(v_next_s - V_START_C);
    end else begin
      x_next_s = 10'd0;
      y_next_s = 9'd0;
    end
  end

endmodule
